// File: rtl/alu_pkg.sv
//==============================================================================
// Package : alu_pkg
// Purpose : Vector-ALU geometry shared between the ALU and its result path.
// Rev     : 1.0
//==============================================================================
`default_nettype none

package alu_pkg;

    localparam int ALU_DATA_WIDTH     = 16;
    localparam int ALU_DIM_SIZE       = 128;
    localparam int SER_LANES_PER_BEAT = 8;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : alu_pkg

`default_nettype wire

// File: rtl/vec_pingpong_buf.sv
//==============================================================================
// Module  : vec_pingpong_buf
// Purpose : Two-slot result-vector store, filled and drained in arrival order.
// Rev     : 1.0
//==============================================================================
`default_nettype none

module vec_pingpong_buf
    import alu_pkg::*;
#(
    parameter int data_width = ALU_DATA_WIDTH,
    parameter int dim_size   = ALU_DIM_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [data_width-1:0] push_data_i [dim_size],
    input  logic                  pop_i,
    output logic [1:0]            full_o,
    output logic                  other_full_o,
    output logic [data_width-1:0] head_data_o [dim_size]
);

    logic [data_width-1:0] mem_q [2][dim_size];
    logic [1:0]            full_q;
    logic [1:0]            full_d;
    logic                  head_q;
    logic                  head_d;
    logic                  tail_q;
    logic                  tail_d;

    // With both slots full tail equals head, so a push paired with a pop
    // refills the slot being released and the full flag stays set.
    always_comb begin
        full_d = full_q;
        if (pop_i) begin
            full_d[head_q] = 1'b0;
        end
        if (push_i) begin
            full_d[tail_q] = 1'b1;
        end
        head_d = head_q ^ pop_i;
        tail_d = tail_q ^ push_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 2'b00;
            head_q <= 1'b0;
            tail_q <= 1'b0;
        end else begin
            full_q <= full_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            for (int i = 0; i < dim_size; i++) begin
                mem_q[tail_q][i] <= push_data_i[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < dim_size; i++) begin
            head_data_o[i] = mem_q[head_q][i];
        end
    end

    assign full_o       = full_q;
    assign other_full_o = full_q[~head_q];

endmodule : vec_pingpong_buf

`default_nettype wire

// File: rtl/alu_res_serializer.sv
//==============================================================================
// Module  : alu_res_serializer
// Purpose : Streams buffered ALU result vectors out as valid/ready beats.
// Rev     : 1.0
//==============================================================================
`default_nettype none

module alu_res_serializer
    import alu_pkg::*;
#(
    parameter int data_width     = ALU_DATA_WIDTH,
    parameter int dim_size       = ALU_DIM_SIZE,
    parameter int lanes_per_beat = SER_LANES_PER_BEAT
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 valid_i,
    input  logic [data_width-1:0]                res_i [dim_size],
    output logic                                 ready_o,
    output logic                                 m_valid_o,
    input  logic                                 m_ready_i,
    output logic [lanes_per_beat*data_width-1:0] m_data_o,
    output logic                                 m_last_o,
    output logic                                 ovf_o,
    input  logic                                 clr_i
);

    localparam int NB = dim_size / lanes_per_beat;
    localparam int BW = clog2_min1(NB);
    localparam int IW = clog2_min1(dim_size);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    if ((dim_size % lanes_per_beat) != 0) begin : g_param_check
        $error("dim_size must be a multiple of lanes_per_beat");
    end

    logic [0:0]            state_q;
    logic [0:0]            state_d;
    logic [BW-1:0]         beat_q;
    logic [BW-1:0]         beat_d;
    logic                  ovf_q;
    logic                  ovf_d;

    logic [1:0]            full;
    logic                  other_full;
    logic [data_width-1:0] head_vec [dim_size];

    logic                  xfer;
    logic                  last_beat;
    logic                  last_xfer;
    logic                  push;
    logic                  drop;

    logic [lanes_per_beat-1:0][data_width-1:0] beat_data;
    logic [IW-1:0]                             lane_idx;

    vec_pingpong_buf #(
        .data_width (data_width),
        .dim_size   (dim_size)
    ) u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .push_data_i  (res_i),
        .pop_i        (last_xfer),
        .full_o       (full),
        .other_full_o (other_full),
        .head_data_o  (head_vec)
    );

    assign ready_o   = ~(full[0] & full[1]);
    assign m_valid_o = (state_q == ST_SEND);
    assign last_beat = (beat_q == BW'(NB - 1));
    assign m_last_o  = m_valid_o & last_beat;

    // A slot released by a last-beat transfer can take a new vector on the
    // same edge, so capture is allowed even while ready_o is low.
    always_comb begin
        xfer      = m_valid_o & m_ready_i;
        last_xfer = xfer & last_beat;
        push      = valid_i & (ready_o | last_xfer);
        drop      = valid_i & ~ready_o & ~last_xfer;
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (push) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    if (last_beat) begin
                        beat_d = '0;
                        if (!(other_full || push)) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            ovf_q   <= ovf_d;
        end
    end

    // Lane mux straight off the head slot; forced to zero when idle so the
    // bus reads 0 out of reset without resetting the vector storage.
    always_comb begin
        lane_idx = '0;
        for (int l = 0; l < lanes_per_beat; l++) begin
            lane_idx     = IW'(int'(beat_q) * lanes_per_beat + l);
            beat_data[l] = head_vec[lane_idx];
        end
    end

    assign m_data_o = m_valid_o ? beat_data : '0;
    assign ovf_o    = ovf_q;

endmodule : alu_res_serializer

`default_nettype wire

// File: tb/tb_alu_res_serializer.sv
//==============================================================================
// Module  : tb_alu_res_serializer
// Purpose : Self-checking bench for alu_res_serializer (default geometry).
// Rev     : 1.0
//==============================================================================
`default_nettype none

module tb_alu_res_serializer;

    localparam int DW  = 16;
    localparam int DIM = 128;
    localparam int LPB = 8;
    localparam int NBT = DIM / LPB;

    typedef struct {
        logic [LPB*DW-1:0] data;
        logic              last;
    } beat_t;

    typedef struct {
        logic [15:0] base;
        logic [15:0] step;
        logic [3:0]  rdy;
        logic [15:0] lane0;
        logic [15:0] lastlane;
    } vec_rec_t;

    logic              clk;
    logic              rst_n;
    logic              valid_i;
    logic [DW-1:0]     res_i [DIM];
    logic              ready_o;
    logic              m_valid_o;
    logic              m_ready_i;
    logic [LPB*DW-1:0] m_data_o;
    logic              m_last_o;
    logic              ovf_o;
    logic              clr_i;

    int                checks;
    int                failures;
    beat_t             exp_q [$];
    logic [3:0]        rdy_pat;
    int                nbeats;
    int                cyc;
    logic [LPB*DW-1:0] beat_log [1024];
    int                beat_cyc [1024];
    vec_rec_t          tbl [4];

    alu_res_serializer #(
        .data_width     (DW),
        .dim_size       (DIM),
        .lanes_per_beat (LPB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   (valid_i),
        .res_i     (res_i),
        .ready_o   (ready_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_data_o  (m_data_o),
        .m_last_o  (m_last_o),
        .ovf_o     (ovf_o),
        .clr_i     (clr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [127:0] act,
                                input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Drives one vector for a single capture edge; returns at posedge+1.
    task automatic drive_vec(input logic [15:0] base, input logic [15:0] step,
                             input bit accept, input bit clr);
        beat_t bt;
        valid_i = 1'b1;
        clr_i   = clr;
        for (int i = 0; i < DIM; i++) begin
            res_i[i] = base + 16'(int'(step) * i);
        end
        if (accept) begin
            for (int k = 0; k < NBT; k++) begin
                for (int l = 0; l < LPB; l++) begin
                    bt.data[l*DW +: DW] = res_i[k*LPB + l];
                end
                bt.last = (k == NBT - 1);
                exp_q.push_back(bt);
            end
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        clr_i   = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_valid_o) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 2000) begin
            failures++;
            $display("FAIL %s: actual=timeout left=%0d required=drained", name, exp_q.size());
        end
    endtask

    task automatic pulse_clr();
        clr_i = 1'b1;
        @(posedge clk);
        #1;
        clr_i = 1'b0;
    endtask

    initial begin
        int b0;
        int n;
        checks    = 0;
        failures  = 0;
        nbeats    = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        valid_i   = 1'b0;
        clr_i     = 1'b0;
        m_ready_i = 1'b0;
        rdy_pat   = 4'b1111;
        for (int i = 0; i < DIM; i++) res_i[i] = '0;

        tbl[0] = '{base: 16'h0000, step: 16'h0001, rdy: 4'b1111, lane0: 16'h0000, lastlane: 16'h007F};
        tbl[1] = '{base: 16'h1000, step: 16'h0003, rdy: 4'b1001, lane0: 16'h1000, lastlane: 16'h117D};
        tbl[2] = '{base: 16'hFFF0, step: 16'h0101, rdy: 4'b0101, lane0: 16'hFFF0, lastlane: 16'h7F6F};
        tbl[3] = '{base: 16'hA5A5, step: 16'hFFFF, rdy: 4'b1110, lane0: 16'hA5A5, lastlane: 16'hA526};

        fork
            // Scoreboard monitor: a beat transfers on the next posedge when
            // valid and ready are both high at this negedge.
            forever begin
                logic              hold_v;
                logic [LPB*DW-1:0] hold_d;
                logic              hold_l;
                beat_t             e;
                hold_v = 1'b0;
                hold_d = '0;
                hold_l = 1'b0;
                forever begin
                    @(negedge clk);
                    cyc++;
                    if (!rst_n || !m_valid_o) begin
                        hold_v = 1'b0;
                        continue;
                    end
                    if (hold_v) begin
                        chk("stall_data", 128'(m_data_o), 128'(hold_d));
                        chk("stall_last", 128'(m_last_o), 128'(hold_l));
                    end
                    if (m_ready_i) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_beat: actual=%0h required=no_beat", m_data_o);
                        end else begin
                            e = exp_q.pop_front();
                            chk("beat_data", 128'(m_data_o), 128'(e.data));
                            chk("beat_last", 128'(m_last_o), 128'(e.last));
                        end
                        beat_log[nbeats] = m_data_o;
                        beat_cyc[nbeats] = cyc;
                        nbeats++;
                        hold_v = 1'b0;
                    end else begin
                        hold_v = 1'b1;
                        hold_d = m_data_o;
                        hold_l = m_last_o;
                    end
                end
            end
            begin
                int rc;
                rc = 0;
                forever begin
                    @(posedge clk);
                    #1;
                    m_ready_i = rdy_pat[rc % 4];
                    rc++;
                end
            end
            begin
                #2000000;
                $display("FAIL watchdog: actual=running required=finished");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", 128'(m_valid_o), 128'(0));
        chk("rst_m_last",  128'(m_last_o),  128'(0));
        chk("rst_ovf",     128'(ovf_o),     128'(0));
        chk("rst_ready",   128'(ready_o),   128'(1));
        chk("rst_m_data",  128'(m_data_o),  128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_reset", 128'(m_valid_o), 128'(0));

        // Single vectors under several backpressure patterns
        for (int t = 0; t < 4; t++) begin
            rdy_pat = tbl[t].rdy;
            repeat (2) @(posedge clk);
            #1;
            b0 = nbeats;
            chk("idle_before", 128'(m_valid_o), 128'(0));
            drive_vec(tbl[t].base, tbl[t].step, 1'b1, 1'b0);
            chk("latency1", 128'(m_valid_o), 128'(1));
            wait_drain("drain_single");
            chk("beat_count", 128'(nbeats - b0), 128'(NBT));
            chk("first_lane", 128'(beat_log[b0][15:0]), 128'(tbl[t].lane0));
            chk("last_lane", 128'(beat_log[b0+NBT-1][LPB*DW-1 -: DW]), 128'(tbl[t].lastlane));
            chk("ovf_single", 128'(ovf_o), 128'(0));
        end

        // Two vectors back to back: no bubble at the boundary
        rdy_pat = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        b0 = nbeats;
        drive_vec(16'h2000, 16'h0001, 1'b1, 1'b0);
        drive_vec(16'h3000, 16'h0002, 1'b1, 1'b0);
        chk("ready_low_two_full", 128'(ready_o), 128'(0));
        wait_drain("drain_pair");
        chk("pair_count", 128'(nbeats - b0), 128'(2*NBT));
        chk("pair_no_gap", 128'(beat_cyc[b0+2*NBT-1] - beat_cyc[b0]), 128'(2*NBT-1));

        // Overflow while stalled, sticky flag, clear, set-wins
        rdy_pat = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        b0 = nbeats;
        drive_vec(16'h4000, 16'h0001, 1'b1, 1'b0);
        drive_vec(16'h5000, 16'h0001, 1'b1, 1'b0);
        chk("ready_full_stall", 128'(ready_o), 128'(0));
        chk("ovf_before_drop", 128'(ovf_o), 128'(0));
        drive_vec(16'hDEAD, 16'h0007, 1'b0, 1'b0);
        chk("ovf_set", 128'(ovf_o), 128'(1));
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_sticky", 128'(ovf_o), 128'(1));
        pulse_clr();
        chk("ovf_cleared", 128'(ovf_o), 128'(0));
        drive_vec(16'hBEEF, 16'h0005, 1'b0, 1'b1);
        chk("ovf_set_wins", 128'(ovf_o), 128'(1));
        pulse_clr();
        chk("ovf_cleared2", 128'(ovf_o), 128'(0));
        rdy_pat = 4'b1111;
        wait_drain("drain_ovf");
        chk("ovf_count", 128'(nbeats - b0), 128'(2*NBT));

        // Third vector lands on the head slot's last-beat edge
        repeat (2) @(posedge clk);
        #1;
        b0 = nbeats;
        drive_vec(16'h6000, 16'h0001, 1'b1, 1'b0);
        drive_vec(16'h7000, 16'h0001, 1'b1, 1'b0);
        repeat (NBT - 2) @(posedge clk);
        #1;
        chk("ready_low_pre_swap", 128'(ready_o), 128'(0));
        drive_vec(16'h8000, 16'h0001, 1'b1, 1'b0);
        chk("ovf_swap", 128'(ovf_o), 128'(0));
        chk("ready_after_swap", 128'(ready_o), 128'(0));
        wait_drain("drain_swap");
        chk("swap_count", 128'(nbeats - b0), 128'(3*NBT));
        chk("swap_no_gap", 128'(beat_cyc[b0+3*NBT-1] - beat_cyc[b0]), 128'(3*NBT-1));
        chk("ovf_swap_end", 128'(ovf_o), 128'(0));

        // Reset in the middle of a vector
        repeat (2) @(posedge clk);
        #1;
        b0 = nbeats;
        drive_vec(16'h9000, 16'h0001, 1'b1, 1'b0);
        n = 0;
        while ((nbeats - b0) < 5 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_beat5", 128'(nbeats - b0), 128'(5));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", 128'(m_valid_o), 128'(0));
        chk("midrst_ready",   128'(ready_o),   128'(1));
        chk("midrst_m_last",  128'(m_last_o),  128'(0));
        chk("midrst_m_data",  128'(m_data_o),  128'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_resume", 128'(m_valid_o), 128'(0));
        b0 = nbeats;
        drive_vec(16'hC000, 16'h0002, 1'b1, 1'b0);
        chk("post_rst_latency", 128'(m_valid_o), 128'(1));
        wait_drain("drain_post_rst");
        chk("post_rst_count", 128'(nbeats - b0), 128'(NBT));
        chk("post_rst_lane0", 128'(beat_log[b0][15:0]), 128'(16'hC000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_res_serializer

`default_nettype wire

// File: doc/alu_res_serializer.md
ALU_RES_SERIALIZER -- requirements
Module: alu_res_serializer

Interface
REQ-001 Parameter data_width, default 16, shall set the bit width of one lane element.
REQ-002 Parameter dim_size, default 128, shall set the number of lanes per result vector.
REQ-003 Parameter lanes_per_beat, default 8, shall set the lanes per output beat; dim_size shall be an integer multiple of it.
REQ-004 clk  input  1  shall be the single clock; all state shall update on its rising edge.
REQ-005 rst_n  input  1  shall be the asynchronous, active-low reset.
REQ-006 valid_i  input  1  shall be the one-cycle result-valid pulse from the vector ALU.
REQ-007 res_i  input  data_width x dim_size (unpacked array)  shall carry the result vector, sampled when valid_i=1.
REQ-008 ready_o  output  1  shall be high when at least one buffer slot is free.
REQ-009 m_valid_o  output  1  shall mark a valid output beat.
REQ-010 m_ready_i  input  1  shall be the downstream acceptance signal.
REQ-011 m_data_o  output  lanes_per_beat*data_width  shall carry one beat; the lowest lane index shall sit in the LSBs.
REQ-012 m_last_o  output  1  shall be high on the final beat of a vector.
REQ-013 ovf_o  output  1  shall be a sticky flag for a dropped vector.
REQ-014 clr_i  input  1  shall synchronously clear ovf_o.

Function
REQ-015 Storage shall be two vector slots (ping-pong) used in arrival order.
REQ-016 A vector shall be captured on the rising edge where valid_i=1 and ready_o=1.
REQ-017 Beat count per vector shall be NB = dim_size/lanes_per_beat; beat k shall carry lanes k*lanes_per_beat through k*lanes_per_beat+lanes_per_beat-1.
REQ-018 The FSM shall have states IDLE (no slot full, m_valid_o=0) and SEND (head slot streaming, m_valid_o=1).
REQ-019 The FSM shall move IDLE->SEND on capture and shall present beat 0 in the cycle after the capture edge (latency 1).
REQ-020 A beat shall transfer on the edge where m_valid_o and m_ready_i are both high; the beat counter shall then increment.
REQ-021 m_data_o and m_last_o shall stay stable while m_valid_o=1 and m_ready_i=0.
REQ-022 m_last_o shall be high only when the beat counter equals NB-1.
REQ-023 On transfer of the last beat, the counter shall wrap to 0 and the head slot shall be freed.
REQ-024 After a last-beat transfer, the FSM shall stay in SEND if the other slot is full, with no bubble cycle; otherwise it shall return to IDLE.
REQ-025 If valid_i=1 with both slots full and no last-beat transfer on that edge, the vector shall be dropped, slot contents shall be unchanged and ovf_o shall be set.
REQ-026 If valid_i=1 with both slots full and a last-beat transfer on the same edge, the freed slot shall accept the vector with no overflow.
REQ-027 ready_o shall be combinationally derived from the slot-full flags only and shall not depend on m_ready_i.
REQ-028 If clr_i and a new overflow coincide, ovf_o shall be set (set wins).

Reset
REQ-029 While rst_n=0: FSM=IDLE, both slots empty, beat counter=0, m_valid_o=0, m_last_o=0, ovf_o=0, ready_o=1.
REQ-030 m_data_o shall reset to 0; slot data storage need not be reset.
REQ-031 Reset asserted mid-vector shall discard all buffered data, and no beats shall resume after release.

Structure
REQ-032 Defaults for data_width and dim_size shall be shared with the vector ALU through package alu_pkg.
REQ-033 The two-slot storage with its full flags and head/tail pointers shall be sub-module vec_pingpong_buf; the FSM, counter, lane mux and overflow logic shall live in the top module.

Verification
REQ-034 Single vector, res_i[i]=i, m_ready_i=1: beats start 1 cycle after valid_i; 16 consecutive beats; beat 0 = lanes 0..7; m_last_o only on beat 15.
REQ-035 Backpressure, m_ready_i toggling 1,0,0,1: m_data_o holds during stalls; all 16 beats are delivered in order.
REQ-036 Two vectors on consecutive cycles: ready_o falls after the second capture; 32 beats are delivered with no gap at the vector boundary.
REQ-037 Third vector while both slots are full and m_ready_i=0: vector dropped, ovf_o=1 and held; clr_i pulse returns it to 0.
REQ-038 Third vector on the same edge as the last-beat transfer of the head slot: vector accepted, ovf_o stays 0, 48 beats total.
REQ-039 rst_n pulsed low at beat 5: m_valid_o drops immediately, ready_o=1, and after release the next vector starts from beat 0.
